// File: rtl/hist_eq_ctrl_pkg.sv
// Shared types and constants for the histogram-equalization frame sequencer.
package hist_eq_ctrl_pkg;

    localparam int HIST_LEVELS         = 256;
    localparam int GRAY_W              = 8;
    localparam int C_CNT_WIDTH_DEFAULT = 20;

    // Last bin index cleared in INIT, and the final SCAN count (one address-lead cycle past bin 255).
    localparam logic [8:0] INIT_LAST = 9'(HIST_LEVELS - 1);
    localparam logic [8:0] SCAN_LAST = 9'(HIST_LEVELS);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_COUNT,
        ST_DRAIN,
        ST_SCAN
    } state_t;

endpackage

// File: rtl/hist_rmw_fwd.sv
// Read-modify-write increment pipeline for histogram counting.
// The read issued at cycle t returns at t+1, when the saturated increment is written back.
// A one-deep forward register covers the write that lands on the same edge as the read,
// so the result does not depend on the RAM's read-during-write behaviour.
module hist_rmw_fwd
    import hist_eq_ctrl_pkg::*;
#(
    parameter int C_CNT_WIDTH = C_CNT_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [GRAY_W-1:0]      gray,
    input  logic [C_CNT_WIDTH-1:0] rd_data,
    output logic                   wr_en,
    output logic [GRAY_W-1:0]      wr_addr,
    output logic [C_CNT_WIDTH-1:0] wr_data
);

    logic                   stg_vld;
    logic [GRAY_W-1:0]      stg_addr;
    logic                   fwd_vld;
    logic [GRAY_W-1:0]      fwd_addr;
    logic [C_CNT_WIDTH-1:0] fwd_data;
    logic [C_CNT_WIDTH-1:0] base;

    // Pipeline stage for the pending pixel, plus a copy of the write just issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld  <= 1'b0;
            stg_addr <= '0;
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
        end else begin
            stg_vld  <= en;
            stg_addr <= gray;
            fwd_vld  <= stg_vld;
            fwd_addr <= stg_addr;
            fwd_data <= wr_data;
        end
    end

    // Use the in-flight write when it targets our bin, then increment without wrapping.
    always_comb begin
        base = rd_data;
        if (fwd_vld && (fwd_addr == stg_addr)) begin
            base = fwd_data;
        end
        wr_data = (&base) ? base : base + {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    assign wr_en   = stg_vld;
    assign wr_addr = stg_addr;

endmodule

// File: rtl/hist_eq_ctrl.sv
// Frame-level sequencer: clears the histogram RAM, counts grey levels during the frame,
// then in blanking streams the cumulative histogram while zeroing each bin.
//
//  state | meaning
//  INIT  | write 0 to bins 0..255 (first cycle after reset is idle)
//  IDLE  | wait for vsync rising edge
//  COUNT | per-pixel read-modify-write into the histogram
//  DRAIN | let the last increment write land; clear accumulator
//  SCAN  | read bins 0..255, emit running sum, write 0 back
module hist_eq_ctrl
    import hist_eq_ctrl_pkg::*;
#(
    parameter int C_CNT_WIDTH = C_CNT_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   per_img_vsync,
    input  logic                   per_img_href,
    input  logic [GRAY_W-1:0]      per_img_gray,
    output logic [GRAY_W-1:0]      hist_rd_addr,
    input  logic [C_CNT_WIDTH-1:0] hist_rd_data,
    output logic                   hist_wr_en,
    output logic [GRAY_W-1:0]      hist_wr_addr,
    output logic [C_CNT_WIDTH-1:0] hist_wr_data,
    output logic [GRAY_W-1:0]      pixel_level,
    output logic [C_CNT_WIDTH-1:0] pixel_level_acc_num,
    output logic                   pixel_level_valid,
    output logic                   busy,
    output logic                   lut_update_done,
    output logic                   frame_drop
);

    state_t                 state, state_nxt;
    logic                   vsync_q;
    logic                   run;
    logic [8:0]             cnt;
    logic [C_CNT_WIDTH-1:0] acc;
    logic [C_CNT_WIDTH:0]   acc_wide;
    logic [C_CNT_WIDTH-1:0] acc_sum;
    logic [GRAY_W-1:0]      lvl;
    logic                   vs_rise, vs_fall;
    logic                   scan_vld;
    logic                   rmw_en;
    logic                   rmw_wr_en;
    logic [GRAY_W-1:0]      rmw_wr_addr;
    logic [C_CNT_WIDTH-1:0] rmw_wr_data;

    assign vs_rise  = per_img_vsync & ~vsync_q;
    assign vs_fall  = ~per_img_vsync & vsync_q;
    assign rmw_en   = (state == ST_COUNT) && per_img_href;
    assign scan_vld = (state == ST_SCAN) && (cnt != 9'd0);
    assign lvl      = cnt[7:0] - 8'd1;
    assign acc_wide = {1'b0, acc} + {1'b0, hist_rd_data};
    assign acc_sum  = acc_wide[C_CNT_WIDTH] ? '1 : acc_wide[C_CNT_WIDTH-1:0];

    hist_rmw_fwd #(
        .C_CNT_WIDTH(C_CNT_WIDTH)
    ) u_rmw (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rmw_en),
        .gray    (per_img_gray),
        .rd_data (hist_rd_data),
        .wr_en   (rmw_wr_en),
        .wr_addr (rmw_wr_addr),
        .wr_data (rmw_wr_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and RAM/stream port muxing.
    always_comb begin
        state_nxt           = state;
        hist_rd_addr        = '0;
        hist_wr_en          = 1'b0;
        hist_wr_addr        = '0;
        hist_wr_data        = '0;
        pixel_level         = '0;
        pixel_level_acc_num = '0;
        pixel_level_valid   = 1'b0;
        busy                = 1'b0;
        case (state)
            ST_INIT: begin
                // run gates the clear so every output reads 0 while reset is held.
                busy         = run;
                hist_wr_en   = run;
                hist_wr_addr = cnt[7:0];
                if (run && (cnt == INIT_LAST)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (vs_rise) begin
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                hist_rd_addr = per_img_gray;
                hist_wr_en   = rmw_wr_en;
                hist_wr_addr = rmw_wr_addr;
                hist_wr_data = rmw_wr_data;
                if (vs_fall) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy         = 1'b1;
                hist_wr_en   = rmw_wr_en;
                hist_wr_addr = rmw_wr_addr;
                hist_wr_data = rmw_wr_data;
                state_nxt    = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (cnt != SCAN_LAST) begin
                    hist_rd_addr = cnt[7:0];
                end
                if (scan_vld) begin
                    pixel_level         = lvl;
                    pixel_level_acc_num = acc_sum;
                    pixel_level_valid   = 1'b1;
                    hist_wr_en          = 1'b1;
                    hist_wr_addr        = lvl;
                end
                if (cnt == SCAN_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Bin counter, accumulator, vsync edge history and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            acc             <= '0;
            run             <= 1'b0;
            vsync_q         <= 1'b0;
            lut_update_done <= 1'b0;
            frame_drop      <= 1'b0;
        end else begin
            vsync_q         <= per_img_vsync;
            run             <= 1'b1;
            lut_update_done <= (state == ST_SCAN) && (cnt == SCAN_LAST);
            frame_drop      <= vs_rise && (state inside {ST_INIT, ST_DRAIN, ST_SCAN});
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (((state == ST_INIT) && run) || (state == ST_SCAN)) begin
                cnt <= cnt + 9'd1;
            end
            if (state == ST_DRAIN) begin
                acc <= '0;
            end else if (scan_vld) begin
                acc <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_hist_eq_ctrl.sv
// Bench for hist_eq_ctrl: a 20-bit and a 4-bit instance share stimulus, each with its own
// histogram RAM model. Expected LUT streams are queued when a frame is driven and popped
// as entries appear.
module tb_hist_eq_ctrl;

    localparam int W     = 20;
    localparam int WS    = 4;
    localparam int MAX_W = (1 << W) - 1;
    localparam int MAX_S = (1 << WS) - 1;

    typedef struct {
        logic [7:0]   lvl;
        logic [W-1:0] acc;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          per_img_vsync = 1'b0;
    logic          per_img_href = 1'b0;
    logic [7:0]    per_img_gray = 8'd0;
    logic          preload = 1'b0;

    logic [7:0]    hist_rd_addr, hist_wr_addr, pixel_level;
    logic [W-1:0]  hist_rd_data, hist_wr_data, pixel_level_acc_num;
    logic          hist_wr_en, pixel_level_valid, busy, lut_update_done, frame_drop;

    logic [7:0]    s_rd_addr, s_wr_addr, s_level;
    logic [WS-1:0] s_rd_data, s_wr_data, s_acc;
    logic          s_wr_en, s_valid, s_busy, s_done, s_drop;

    logic [W-1:0]  ram   [256];
    logic [WS-1:0] ram_s [256];
    logic          outs_any;

    ent_t q[$];
    ent_t q_s[$];
    int   checks = 0;
    int   errors = 0;
    int   drop_cnt = 0;

    hist_eq_ctrl #(.C_CNT_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(per_img_vsync), .per_img_href(per_img_href), .per_img_gray(per_img_gray),
        .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
        .hist_wr_en(hist_wr_en), .hist_wr_addr(hist_wr_addr), .hist_wr_data(hist_wr_data),
        .pixel_level(pixel_level), .pixel_level_acc_num(pixel_level_acc_num),
        .pixel_level_valid(pixel_level_valid), .busy(busy),
        .lut_update_done(lut_update_done), .frame_drop(frame_drop)
    );

    hist_eq_ctrl #(.C_CNT_WIDTH(WS)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(per_img_vsync), .per_img_href(per_img_href), .per_img_gray(per_img_gray),
        .hist_rd_addr(s_rd_addr), .hist_rd_data(s_rd_data),
        .hist_wr_en(s_wr_en), .hist_wr_addr(s_wr_addr), .hist_wr_data(s_wr_data),
        .pixel_level(s_level), .pixel_level_acc_num(s_acc),
        .pixel_level_valid(s_valid), .busy(s_busy),
        .lut_update_done(s_done), .frame_drop(s_drop)
    );

    assign outs_any = |{hist_rd_addr, hist_wr_en, hist_wr_addr, hist_wr_data, pixel_level,
                        pixel_level_acc_num, pixel_level_valid, busy, lut_update_done, frame_drop,
                        s_wr_en, s_valid, s_busy, s_done, s_drop};

    // Clock.
    always #5 clk = ~clk;

    // Synchronous RAM models, read-old-during-write; preload fills them with nonzero garbage.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                ram[i]   <= W'($urandom) | W'(1);
                ram_s[i] <= WS'($urandom) | WS'(1);
            end
        end else begin
            hist_rd_data <= ram[hist_rd_addr];
            s_rd_data    <= ram_s[s_rd_addr];
            if (hist_wr_en) ram[hist_wr_addr] <= hist_wr_data;
            if (s_wr_en)    ram_s[s_wr_addr]  <= s_wr_data;
        end
    end

    // Scoreboard: pop and compare each emitted LUT entry on both instances.
    always @(negedge clk) begin : mon
        ent_t e;
        if (frame_drop) drop_cnt++;
        if (rst_n && pixel_level_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL stream20 unexpected entry level %0d acc %0d", pixel_level, pixel_level_acc_num);
            end else begin
                e = q.pop_front();
                if (pixel_level !== e.lvl || pixel_level_acc_num !== e.acc) begin
                    errors++;
                    $display("FAIL stream20 got level %0d acc %0d, expected level %0d acc %0d",
                             pixel_level, pixel_level_acc_num, e.lvl, e.acc);
                end
            end
        end
        if (rst_n && s_valid) begin
            checks++;
            if (q_s.size() == 0) begin
                errors++;
                $display("FAIL stream4 unexpected entry level %0d acc %0d", s_level, s_acc);
            end else begin
                e = q_s.pop_front();
                if (s_level !== e.lvl || {{(W-WS){1'b0}}, s_acc} !== e.acc) begin
                    errors++;
                    $display("FAIL stream4 got level %0d acc %0d, expected level %0d acc %0d",
                             s_level, s_acc, e.lvl, e.acc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Saturating histogram / cumulative-sum model for both widths.
    task automatic push_expect(input logic [7:0] pix[$]);
        int   h [256];
        int   hs[256];
        int   c, cs;
        ent_t e;
        for (int k = 0; k < 256; k++) begin
            h[k] = 0;
            hs[k] = 0;
        end
        foreach (pix[i]) begin
            if (h[pix[i]] < MAX_W)  h[pix[i]]++;
            if (hs[pix[i]] < MAX_S) hs[pix[i]]++;
        end
        c = 0;
        cs = 0;
        for (int k = 0; k < 256; k++) begin
            c  = (c + h[k] > MAX_W) ? MAX_W : c + h[k];
            cs = (cs + hs[k] > MAX_S) ? MAX_S : cs + hs[k];
            e.lvl = 8'(k);
            e.acc = W'(c);
            q.push_back(e);
            e.acc = W'(cs);
            q_s.push_back(e);
        end
    endtask

    // Drives one frame; returns just after vsync has been dropped.
    task automatic send_frame(input logic [7:0] pix[$], input int cols, input int gap);
        per_img_vsync = 1'b1;
        tick();
        tick();
        for (int i = 0; i < pix.size(); i++) begin
            per_img_href = 1'b1;
            per_img_gray = pix[i];
            tick();
            if (((i + 1) % cols == 0) && gap > 0) begin
                per_img_href = 1'b0;
                repeat (gap) tick();
            end
        end
        per_img_href = 1'b0;
        per_img_vsync = 1'b0;
    endtask

    // Counts edges until lut_update_done, bounded.
    task automatic wait_done(input int start, output int n);
        n = start;
        while (n < 600) begin
            tick();
            n++;
            if (lut_update_done) break;
        end
    endtask

    // After reset release: count busy cycles and clearing writes, then scan the RAMs.
    task automatic check_init(input string tag);
        int busy_n = 0, wr_n = 0, bad = 0, nz = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (hist_wr_en) begin
                if (hist_wr_addr !== 8'(wr_n) || hist_wr_data !== '0) bad++;
                wr_n++;
            end
        end
        checks++;
        if (busy_n !== 256) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected 256", tag, busy_n);
        end
        checks++;
        if (wr_n !== 256 || bad !== 0) begin
            errors++;
            $display("FAIL %s init_writes got %0d writes (%0d bad) expected 256 zero writes in order", tag, wr_n, bad);
        end
        for (int i = 0; i < 256; i++) if (ram[i] !== '0 || ram_s[i] !== '0) nz++;
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL %s ram_cleared got %0d nonzero bins expected 0", tag, nz);
        end
    endtask

    task automatic check_empty(input string tag);
        checks++;
        if (q.size() !== 0 || q_s.size() !== 0) begin
            errors++;
            $display("FAIL %s stream_len got %0d/%0d entries left expected 0/0", tag, q.size(), q_s.size());
        end
    endtask

    task automatic test_reset();
        tick();
        preload = 1'b1;
        tick();
        preload = 1'b0;
        checks++;
        if (outs_any !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0", outs_any);
        end
        rst_n = 1'b1;
        check_init("reset_init");
    endtask

    task automatic test_back_to_back();
        logic [7:0] pix[$];
        int n;
        for (int i = 0; i < 16; i++) pix.push_back(8'd100);
        push_expect(pix);
        send_frame(pix, 4, 0);
        wait_done(0, n);
        checks++;
        if (n !== 259) begin
            errors++;
            $display("FAIL b2b_done_latency got %0d expected 259", n);
        end
        check_empty("b2b");
    endtask

    task automatic test_alternating();
        logic [7:0] pix[$];
        int n;
        for (int i = 0; i < 64; i++) pix.push_back((i % 2) ? 8'd255 : 8'd0);
        push_expect(pix);
        send_frame(pix, 8, 2);
        wait_done(0, n);
        checks++;
        if (n !== 259) begin
            errors++;
            $display("FAIL alt_done_latency got %0d expected 259", n);
        end
        checks++;
        if (ram[255] !== '0 || ram[0] !== '0 || ram_s[255] !== '0) begin
            errors++;
            $display("FAIL alt_bin_cleared got bin255 %0d bin0 %0d expected 0", ram[255], ram[0]);
        end
        check_empty("alt");
    endtask

    task automatic test_random();
        logic [7:0] pix[$];
        int n;
        for (int i = 0; i < 64; i++) pix.push_back(8'($urandom_range(0, 3)));
        push_expect(pix);
        send_frame(pix, 8, 1);
        wait_done(0, n);
        checks++;
        if (n !== 259) begin
            errors++;
            $display("FAIL rand_done_latency got %0d expected 259", n);
        end
        check_empty("rand");
    endtask

    task automatic test_short_blank();
        logic [7:0] pix_a[$];
        logic [7:0] pix_c[$];
        int n, d0;
        for (int i = 0; i < 16; i++) pix_a.push_back(8'd10);
        for (int i = 0; i < 16; i++) pix_c.push_back(8'd50);
        push_expect(pix_a);
        send_frame(pix_a, 4, 2);
        d0 = drop_cnt;
        n = 0;
        repeat (102) begin
            tick();
            n++;
        end
        per_img_vsync = 1'b1;
        for (int i = 0; i < 16; i++) begin
            per_img_href = 1'b1;
            per_img_gray = 8'd200;
            tick();
            n++;
        end
        per_img_href = 1'b0;
        wait_done(n, n);
        checks++;
        if (n !== 259) begin
            errors++;
            $display("FAIL blank_done_latency got %0d expected 259", n);
        end
        checks++;
        if (drop_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL blank_frame_drop got %0d pulses expected 1", drop_cnt - d0);
        end
        check_empty("blank_a");
        per_img_vsync = 1'b0;
        tick();
        tick();
        push_expect(pix_c);
        send_frame(pix_c, 4, 2);
        wait_done(0, n);
        checks++;
        if (n !== 259) begin
            errors++;
            $display("FAIL blank_next_latency got %0d expected 259", n);
        end
        check_empty("blank_c");
    endtask

    task automatic test_saturation();
        logic [7:0] pix[$];
        int n;
        for (int i = 0; i < 20; i++) pix.push_back(8'd7);
        push_expect(pix);
        send_frame(pix, 5, 1);
        tick();
        tick();
        checks++;
        if (ram_s[7] !== 4'd15 || ram[7] !== 20'd20) begin
            errors++;
            $display("FAIL sat_bin7 got narrow %0d wide %0d expected 15 and 20", ram_s[7], ram[7]);
        end
        wait_done(2, n);
        checks++;
        if (n !== 259) begin
            errors++;
            $display("FAIL sat_done_latency got %0d expected 259", n);
        end
        check_empty("sat");
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] pix[$];
        logic [7:0] pix2[$];
        int n;
        for (int i = 0; i < 16; i++) pix.push_back(8'($urandom_range(0, 79)));
        for (int i = 0; i < 16; i++) pix2.push_back(8'($urandom_range(0, 255)));
        push_expect(pix);
        send_frame(pix, 4, 1);
        n = 0;
        while (n < 400 && !(pixel_level_valid === 1'b1 && pixel_level === 8'd50)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL midrst_reach_entry50 got timeout after %0d cycles expected entry 50", n);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_any !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got %b expected 0", outs_any);
        end
        checks++;
        if (q.size() !== 206) begin
            errors++;
            $display("FAIL midrst_entries_before got %0d left expected 206", q.size());
        end
        q.delete();
        q_s.delete();
        tick();
        tick();
        rst_n = 1'b1;
        check_init("midrst_init");
        push_expect(pix2);
        send_frame(pix2, 4, 0);
        wait_done(0, n);
        checks++;
        if (n !== 259) begin
            errors++;
            $display("FAIL midrst_next_latency got %0d expected 259", n);
        end
        check_empty("midrst_next");
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_back_to_back();
        test_alternating();
        test_random();
        test_short_blank();
        test_saturation();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
